// File: rtl/trigger_capture_if.sv
// Bundle of sample, trigger-control and frame-read signals between the
// acquisition stage (slave) and its driver/renderer side (master).
interface trigger_capture_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_sample_valid;
    logic [DATA_WIDTH-1:0] i_sample;
    logic [DATA_WIDTH-1:0] i_level;
    logic                  i_falling;
    logic                  i_auto;
    logic                  i_arm;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic [1:0]            o_state;
    logic                  o_frame_ready;
    logic                  o_trig_pulse;
    logic                  o_forced;

    modport master (
        output i_sample_valid, i_sample, i_level, i_falling, i_auto, i_arm, i_rd_addr,
        input  o_rd_data, o_state, o_frame_ready, o_trig_pulse, o_forced
    );

    modport slave (
        input  i_sample_valid, i_sample, i_level, i_falling, i_auto, i_arm, i_rd_addr,
        output o_rd_data, o_state, o_frame_ready, o_trig_pulse, o_forced
    );
endinterface

// File: rtl/trigger_capture.sv
// Triggered acquisition: circular sample buffer, level-crossing trigger and a
// frozen DEPTH-sample frame read back by screen column with one-cycle latency.
module trigger_capture #(
    parameter int DATA_WIDTH   = 10,
    parameter int DEPTH        = 640,
    parameter int ADDR_WIDTH   = 10,
    parameter int PRETRIG      = 320,
    parameter int AUTO_TIMEOUT = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    trigger_capture_if.slave  bus
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int TO_W   = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      PRE_LAST  = CNT_W'(PRETRIG);
    localparam logic [CNT_W-1:0]      POST_LAST = CNT_W'(DEPTH - PRETRIG);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(AUTO_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
    logic [CNT_W-1:0]      pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d, rd_data_q, rd_data_d;
    logic                  prev_ok_q, prev_ok_d, forced_q, forced_d;
    logic                  frame_ready_q, frame_ready_d, trig_pulse_q, trig_pulse_d;
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic                  we_s, edge_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_next_s, start_wrap_s;
    logic [CNT_W-1:0]      start_sum_s, rd_sum_s;
    logic [MEM_AW-1:0]     rd_phys_s, wr_idx_s;
    logic [TO_W-1:0]       to_inc_s;

    // Write qualification, edge detection and pointer arithmetic
    always_comb begin
        case (state_q)
            S_FILL, S_ARMED, S_POST: we_s = bus.i_sample_valid & ~bus.i_arm;
            default:                 we_s = 1'b0;
        endcase
        if (bus.i_falling) begin
            edge_s = prev_ok_q && (prev_q > bus.i_level) && (bus.i_sample <= bus.i_level);
        end else begin
            edge_s = prev_ok_q && (prev_q < bus.i_level) && (bus.i_sample >= bus.i_level);
        end
        if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_next_s = '0;
        end else begin
            wr_ptr_next_s = wr_ptr_q + ADDR_WIDTH'(1);
        end
        wr_idx_s    = MEM_AW'(wr_ptr_q);
        start_sum_s = {1'b0, wr_ptr_q} + CNT_W'(DEPTH - PRETRIG);
        if (start_sum_s >= DEPTH_C) begin
            start_wrap_s = ADDR_WIDTH'(start_sum_s - DEPTH_C);
        end else begin
            start_wrap_s = ADDR_WIDTH'(start_sum_s);
        end
        // Saturate so a long manual-mode wait never wraps into a false timeout
        if (&to_cnt_q) begin
            to_inc_s = to_cnt_q;
        end else begin
            to_inc_s = to_cnt_q + TO_W'(1);
        end
        rd_sum_s = {1'b0, start_ptr_q} + {1'b0, bus.i_rd_addr};
        if (rd_sum_s >= DEPTH_C) begin
            rd_phys_s = MEM_AW'(rd_sum_s - DEPTH_C);
        end else begin
            rd_phys_s = MEM_AW'(rd_sum_s);
        end
        if ({1'b0, bus.i_rd_addr} < DEPTH_C) begin
            rd_data_d = mem_q[rd_phys_s];
        end else begin
            rd_data_d = '0;
        end
    end

    // Acquisition FSM next-state and counter updates
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        pre_cnt_d     = pre_cnt_q;
        post_cnt_d    = post_cnt_q;
        to_cnt_d      = to_cnt_q;
        prev_d        = prev_q;
        prev_ok_d     = prev_ok_q;
        start_ptr_d   = start_ptr_q;
        forced_d      = forced_q;
        frame_ready_d = frame_ready_q;
        trig_pulse_d  = 1'b0;
        if (we_s) begin
            wr_ptr_d  = wr_ptr_next_s;
            prev_d    = bus.i_sample;
            prev_ok_d = 1'b1;
        end else begin
            wr_ptr_d  = wr_ptr_q;
        end
        if (bus.i_arm) begin
            pre_cnt_d     = '0;
            post_cnt_d    = '0;
            to_cnt_d      = '0;
            prev_ok_d     = 1'b0;
            forced_d      = 1'b0;
            frame_ready_d = 1'b0;
            state_d       = (PRETRIG == 0) ? S_ARMED : S_FILL;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (we_s) begin
                        pre_cnt_d = pre_cnt_q + CNT_W'(1);
                        if (pre_cnt_d == PRE_LAST) begin
                            state_d = S_ARMED;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_ARMED: begin
                    if (we_s) begin
                        to_cnt_d = to_inc_s;
                        if (edge_s || (bus.i_auto && (to_inc_s == TO_LAST))) begin
                            trig_pulse_d = 1'b1;
                            start_ptr_d  = start_wrap_s;
                            post_cnt_d   = CNT_W'(1);
                            forced_d     = forced_q | ~edge_s;
                            if (POST_LAST == CNT_W'(1)) begin
                                state_d       = S_DONE;
                                frame_ready_d = 1'b1;
                            end else begin
                                state_d       = S_POST;
                            end
                        end else begin
                            state_d = S_ARMED;
                        end
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_POST: begin
                    if (we_s) begin
                        post_cnt_d = post_cnt_q + CNT_W'(1);
                        if (post_cnt_d == POST_LAST) begin
                            state_d       = S_DONE;
                            frame_ready_d = 1'b1;
                        end else begin
                            state_d       = S_POST;
                        end
                    end else begin
                        state_d = S_POST;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
            to_cnt_q      <= '0;
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            start_ptr_q   <= '0;
            forced_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            trig_pulse_q  <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            pre_cnt_q     <= pre_cnt_d;
            post_cnt_q    <= post_cnt_d;
            to_cnt_q      <= to_cnt_d;
            prev_q        <= prev_d;
            prev_ok_q     <= prev_ok_d;
            start_ptr_q   <= start_ptr_d;
            forced_q      <= forced_d;
            frame_ready_q <= frame_ready_d;
            trig_pulse_q  <= trig_pulse_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Sample storage; contents carry no reset
    always_ff @(posedge i_clk) begin
        if (we_s) begin
            mem_q[wr_idx_s] <= bus.i_sample;
        end
    end

    // External state code: DONE reads as 0 alongside o_frame_ready
    always_comb begin
        case (state_q)
            S_FILL:  bus.o_state = 2'd1;
            S_ARMED: bus.o_state = 2'd2;
            S_POST:  bus.o_state = 2'd3;
            default: bus.o_state = 2'd0;
        endcase
    end

    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_frame_ready = frame_ready_q;
    assign bus.o_trig_pulse  = trig_pulse_q;
    assign bus.o_forced      = forced_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture with DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=32.
module tb_trigger_capture;
    localparam int DW = 10;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [DW-1:0] rd;

    always #5 clk = ~clk;

    trigger_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    trigger_capture #(
        .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW), .PRETRIG(4), .AUTO_TIMEOUT(32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic send(input logic [DW-1:0] s);
        @(negedge clk);
        bus.i_sample_valid = 1'b1;
        bus.i_sample       = s;
        @(posedge clk);
        #1;
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic arm_pulse(input logic valid, input logic [DW-1:0] s);
        @(negedge clk);
        bus.i_arm          = 1'b1;
        bus.i_sample_valid = valid;
        bus.i_sample       = s;
        @(posedge clk);
        #1;
        bus.i_arm          = 1'b0;
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic read_col(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        bus.i_rd_addr = a;
        @(posedge clk);
        #1;
        d = bus.o_rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.o_state); end
        total++; if (bus.o_frame_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", bus.o_frame_ready); end
        total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b exp=0", bus.o_trig_pulse); end
        total++; if (bus.o_forced !== 1'b0) begin bad++; $display("FAIL reset_forced got=%0b exp=0", bus.o_forced); end
        total++; if (bus.o_rd_data !== 10'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", bus.o_rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_arm();
        for (int i = 0; i < 100; i++) send(10'(1000 + (i % 20)));
        total++; if (bus.o_state !== 2'd0) begin bad++; $display("FAIL noarm_state got=%0d exp=0", bus.o_state); end
        total++; if (bus.o_frame_ready !== 1'b0) begin bad++; $display("FAIL noarm_ready got=%0b exp=0", bus.o_frame_ready); end
    endtask

    task automatic test_ramp();
        bus.i_level = 10'd55; bus.i_falling = 1'b0; bus.i_auto = 1'b0;
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 18; i++) begin
            send(10'(10 * i));
            if (i == 2) begin
                total++; if (bus.o_state !== 2'd1) begin bad++; $display("FAIL ramp_fill got=%0d exp=1", bus.o_state); end
            end
            if (i == 3) begin
                total++; if (bus.o_state !== 2'd2) begin bad++; $display("FAIL ramp_armed got=%0d exp=2", bus.o_state); end
            end
            if (i == 5) begin
                total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL ramp_early_pulse got=%0b exp=0", bus.o_trig_pulse); end
            end
            if (i == 6) begin
                total++; if (bus.o_trig_pulse !== 1'b1) begin bad++; $display("FAIL ramp_pulse got=%0b exp=1", bus.o_trig_pulse); end
                total++; if (bus.o_state !== 2'd3) begin bad++; $display("FAIL ramp_post got=%0d exp=3", bus.o_state); end
            end
            if (i == 16) begin
                total++; if (bus.o_frame_ready !== 1'b0) begin bad++; $display("FAIL ramp_ready_early got=%0b exp=0", bus.o_frame_ready); end
            end
        end
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL ramp_ready got=%0b exp=1", bus.o_frame_ready); end
        total++; if (bus.o_state !== 2'd0) begin bad++; $display("FAIL ramp_done_state got=%0d exp=0", bus.o_state); end
        total++; if (bus.o_forced !== 1'b0) begin bad++; $display("FAIL ramp_forced got=%0b exp=0", bus.o_forced); end
        for (int c = 0; c < 16; c++) begin
            read_col(AW'(c), rd);
            total++; if (rd !== 10'(20 + 10 * c)) begin bad++; $display("FAIL ramp_col%0d got=%0d exp=%0d", c, rd, 20 + 10 * c); end
        end
        read_col(10'd16, rd);
        total++; if (rd !== 10'd0) begin bad++; $display("FAIL ramp_oob got=%0d exp=0", rd); end
        for (int i = 0; i < 5; i++) send(10'd999);
        read_col(10'd0, rd);
        total++; if (rd !== 10'd20) begin bad++; $display("FAIL done_frozen got=%0d exp=20", rd); end
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL done_hold got=%0b exp=1", bus.o_frame_ready); end
    endtask

    task automatic test_falling();
        bus.i_level = 10'd500; bus.i_falling = 1'b1;
        arm_pulse(1'b0, 10'd0);
        total++; if (bus.o_frame_ready !== 1'b0) begin bad++; $display("FAIL arm_clears_ready got=%0b exp=0", bus.o_frame_ready); end
        for (int i = 0; i < 4; i++) send(10'd700);
        send(10'd600);
        send(10'd550);
        total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL fall_early got=%0b exp=0", bus.o_trig_pulse); end
        send(10'd500);
        total++; if (bus.o_trig_pulse !== 1'b1) begin bad++; $display("FAIL fall_pulse got=%0b exp=1", bus.o_trig_pulse); end
        for (int i = 0; i < 11; i++) send(10'd400);
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL fall_ready got=%0b exp=1", bus.o_frame_ready); end
        read_col(10'd0, rd);
        total++; if (rd !== 10'd700) begin bad++; $display("FAIL fall_col0 got=%0d exp=700", rd); end
        read_col(10'd3, rd);
        total++; if (rd !== 10'd550) begin bad++; $display("FAIL fall_col3 got=%0d exp=550", rd); end
        read_col(10'd4, rd);
        total++; if (rd !== 10'd500) begin bad++; $display("FAIL fall_col4 got=%0d exp=500", rd); end
    endtask

    task automatic test_rising_no_trig();
        bus.i_falling = 1'b0;
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'd700);
        send(10'd600);
        send(10'd550);
        send(10'd500);
        total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL rise_notrig_pulse got=%0b exp=0", bus.o_trig_pulse); end
        total++; if (bus.o_state !== 2'd2) begin bad++; $display("FAIL rise_notrig_state got=%0d exp=2", bus.o_state); end
    endtask

    task automatic test_auto();
        bus.i_level = 10'd300; bus.i_auto = 1'b1;
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'd100);
        for (int k = 1; k <= 32; k++) begin
            send(10'd100);
            if (k == 31) begin
                total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL auto_31_pulse got=%0b exp=0", bus.o_trig_pulse); end
                total++; if (bus.o_state !== 2'd2) begin bad++; $display("FAIL auto_31_state got=%0d exp=2", bus.o_state); end
            end
        end
        total++; if (bus.o_trig_pulse !== 1'b1) begin bad++; $display("FAIL auto_32_pulse got=%0b exp=1", bus.o_trig_pulse); end
        total++; if (bus.o_forced !== 1'b1) begin bad++; $display("FAIL auto_forced got=%0b exp=1", bus.o_forced); end
        for (int i = 0; i < 11; i++) send(10'd100);
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL auto_ready got=%0b exp=1", bus.o_frame_ready); end
        total++; if (bus.o_forced !== 1'b1) begin bad++; $display("FAIL auto_forced_hold got=%0b exp=1", bus.o_forced); end
    endtask

    task automatic test_no_auto();
        bus.i_auto = 1'b0;
        arm_pulse(1'b0, 10'd0);
        total++; if (bus.o_forced !== 1'b0) begin bad++; $display("FAIL arm_clears_forced got=%0b exp=0", bus.o_forced); end
        for (int i = 0; i < 1004; i++) send(10'd100);
        total++; if (bus.o_state !== 2'd2) begin bad++; $display("FAIL noauto_state got=%0d exp=2", bus.o_state); end
        total++; if (bus.o_forced !== 1'b0) begin bad++; $display("FAIL noauto_forced got=%0b exp=0", bus.o_forced); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.i_level = 10'd150; bus.i_falling = 1'b0; bus.i_auto = 1'b0;
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 13; i++) send(10'd0);
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'(101 + i));
        send(10'd200);
        total++; if (bus.o_trig_pulse !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%0b exp=1", bus.o_trig_pulse); end
        for (int i = 0; i < 11; i++) send(10'(201 + i));
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%0b exp=1", bus.o_frame_ready); end
        read_col(10'd0, rd);
        total++; if (rd !== 10'd101) begin bad++; $display("FAIL wrap_col0 got=%0d exp=101", rd); end
        read_col(10'd3, rd);
        total++; if (rd !== 10'd104) begin bad++; $display("FAIL wrap_col3 got=%0d exp=104", rd); end
        read_col(10'd4, rd);
        total++; if (rd !== 10'd200) begin bad++; $display("FAIL wrap_col4 got=%0d exp=200", rd); end
        read_col(10'd15, rd);
        total++; if (rd !== 10'd211) begin bad++; $display("FAIL wrap_col15 got=%0d exp=211", rd); end
    endtask

    task automatic test_abort();
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'd10);
        send(10'd200);
        send(10'd201);
        send(10'd202);
        total++; if (bus.o_state !== 2'd3) begin bad++; $display("FAIL abort_pre_state got=%0d exp=3", bus.o_state); end
        arm_pulse(1'b1, 10'd300);
        total++; if (bus.o_state !== 2'd1) begin bad++; $display("FAIL abort_state got=%0d exp=1", bus.o_state); end
        total++; if (bus.o_trig_pulse !== 1'b0) begin bad++; $display("FAIL abort_pulse got=%0b exp=0", bus.o_trig_pulse); end
        for (int i = 0; i < 3; i++) send(10'd10);
        total++; if (bus.o_state !== 2'd1) begin bad++; $display("FAIL abort_discard got=%0d exp=1", bus.o_state); end
        send(10'd10);
        total++; if (bus.o_state !== 2'd2) begin bad++; $display("FAIL abort_refill got=%0d exp=2", bus.o_state); end
    endtask

    task automatic test_async_reset();
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'd10);
        send(10'd200);
        send(10'd201);
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_state !== 2'd0) begin bad++; $display("FAIL arst_post_state got=%0d exp=0", bus.o_state); end
        @(negedge clk);
        rst_n = 1'b1;
        arm_pulse(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send(10'd10);
        send(10'd200);
        for (int i = 0; i < 11; i++) send(10'd220);
        total++; if (bus.o_frame_ready !== 1'b1) begin bad++; $display("FAIL arst_pre_ready got=%0b exp=1", bus.o_frame_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_frame_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%0b exp=0", bus.o_frame_ready); end
        total++; if (bus.o_state !== 2'd0) begin bad++; $display("FAIL arst_done_state got=%0d exp=0", bus.o_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_sample_valid = 1'b0;
        bus.i_sample       = '0;
        bus.i_level        = '0;
        bus.i_falling      = 1'b0;
        bus.i_auto         = 1'b0;
        bus.i_arm          = 1'b0;
        bus.i_rd_addr      = '0;
        test_reset();
        test_no_arm();
        test_ramp();
        test_falling();
        test_rising_no_trig();
        test_auto();
        test_no_auto();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
